// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the 4-bit ALU, its golden model and the
//            runtime result checker: opcode encoding, default datapath width
//            and the bit positions of the per-field mismatch flags.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand / result width of the ALU family.
    localparam int c_width_default = 4;

    // ALU opcode encoding as driven on the op bus.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    // err_flags layout: {result, carry, zero, overflow}.
    localparam int c_err_w        = 4;
    localparam int c_err_result   = 3;
    localparam int c_err_carry    = 2;
    localparam int c_err_zero     = 1;
    localparam int c_err_overflow = 0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_golden_model.sv
`default_nettype none
// ============================================================================
// Module   : alu_golden_model
// Purpose  : Purely combinational reference ALU. Produces the result and the
//            carry / zero / overflow flags the secure ALU is expected to emit
//            for a given operand pair and opcode.
// Ports    : i_a, i_b    - operands (WIDTH bits)
//            i_op        - opcode (ADD / SUB / AND / OR)
//            o_result    - expected result (WIDTH bits)
//            o_carry     - carry out (SUB: 1 = no borrow)
//            o_zero      - result is all zeros
//            o_overflow  - signed overflow (ADD / SUB only)
// Revision : 1.0 - initial release
// ============================================================================
module alu_golden_model
    import alu_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_overflow
);

    // One extra bit so the carry out of the top position is kept.
    logic [WIDTH:0] w_ext;
    logic           w_ovf;

    always_comb begin
        w_ext = '0;
        w_ovf = 1'b0;
        case (op_e'(i_op))
            OP_ADD: begin
                w_ext = {1'b0, i_a} + {1'b0, i_b};
                w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                        (w_ext[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                // Two's-complement subtract; the carry out doubles as the
                // "no borrow" indication (A >= B unsigned).
                w_ext = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
                w_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                        (w_ext[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: w_ext = {1'b0, i_a & i_b};
            OP_OR:  w_ext = {1'b0, i_a | i_b};
            default: begin
                w_ext = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    assign o_result   = w_ext[WIDTH-1:0];
    assign o_carry    = w_ext[WIDTH];
    assign o_zero     = (w_ext[WIDTH-1:0] == '0);
    assign o_overflow = w_ovf;

endmodule : alu_golden_model
`default_nettype wire

// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_checker
// Purpose  : Runtime monitor placed beside a secure ALU. Delays the operands
//            by the ALU latency, recomputes the expected outputs with the
//            golden model, compares field by field, counts checks and
//            mismatches (saturating), captures the first offending
//            transaction and raises a sticky tamper alarm.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            in_valid, A, B, op   - transaction launched into the ALU
//            dut_result/carry/zero/overflow - ALU outputs under test
//            clear                - clears counters, capture and alarm
//            chk_valid, err_valid, err_flags - per-comparison results
//            mismatch_count, check_count     - saturating counters
//            alarm                - sticky tamper alarm
//            cap_valid, cap_A, cap_B, cap_op, cap_result - first mismatch
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int WIDTH        = c_width_default,
    parameter int DUT_LATENCY  = 1,
    parameter int CNT_W        = 8,
    parameter int ALARM_THRESH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   dut_result,
    input  logic               dut_carry,
    input  logic               dut_zero,
    input  logic               dut_overflow,
    input  logic               clear,
    output logic               chk_valid,
    output logic               err_valid,
    output logic [c_err_w-1:0] err_flags,
    output logic [CNT_W-1:0]   mismatch_count,
    output logic [CNT_W-1:0]   check_count,
    output logic               alarm,
    output logic               cap_valid,
    output logic [WIDTH-1:0]   cap_A,
    output logic [WIDTH-1:0]   cap_B,
    output logic [1:0]         cap_op,
    output logic [WIDTH-1:0]   cap_result
);

    localparam logic [CNT_W-1:0] c_thresh  = CNT_W'(ALARM_THRESH);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_ARMED   = 1'b0,
        ST_TRIPPED = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Operand pipeline: stage DUT_LATENCY-1 lines up with the ALU outputs.
    // ------------------------------------------------------------------
    logic             r_pipe_valid [DUT_LATENCY];
    logic [WIDTH-1:0] r_pipe_a     [DUT_LATENCY];
    logic [WIDTH-1:0] r_pipe_b     [DUT_LATENCY];
    logic [1:0]       r_pipe_op    [DUT_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DUT_LATENCY; i++) begin
                r_pipe_valid[i] <= 1'b0;
                r_pipe_a[i]     <= '0;
                r_pipe_b[i]     <= '0;
                r_pipe_op[i]    <= '0;
            end
        end else begin
            r_pipe_valid[0] <= in_valid;
            r_pipe_a[0]     <= A;
            r_pipe_b[0]     <= B;
            r_pipe_op[0]    <= op;
            for (int i = 1; i < DUT_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_a[i]     <= r_pipe_a[i-1];
                r_pipe_b[i]     <= r_pipe_b[i-1];
                r_pipe_op[i]    <= r_pipe_op[i-1];
            end
        end
    end

    logic             w_tail_valid;
    logic [WIDTH-1:0] w_tail_a;
    logic [WIDTH-1:0] w_tail_b;
    logic [1:0]       w_tail_op;

    assign w_tail_valid = r_pipe_valid[DUT_LATENCY-1];
    assign w_tail_a     = r_pipe_a[DUT_LATENCY-1];
    assign w_tail_b     = r_pipe_b[DUT_LATENCY-1];
    assign w_tail_op    = r_pipe_op[DUT_LATENCY-1];

    // ------------------------------------------------------------------
    // Golden model and field comparison
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_gold_result;
    logic             w_gold_carry;
    logic             w_gold_zero;
    logic             w_gold_overflow;

    alu_golden_model #(
        .WIDTH (WIDTH)
    ) u_golden (
        .i_a        (w_tail_a),
        .i_b        (w_tail_b),
        .i_op       (w_tail_op),
        .o_result   (w_gold_result),
        .o_carry    (w_gold_carry),
        .o_zero     (w_gold_zero),
        .o_overflow (w_gold_overflow)
    );

    logic [c_err_w-1:0] w_flags;

    always_comb begin
        w_flags                 = '0;
        w_flags[c_err_result]   = (dut_result   != w_gold_result);
        w_flags[c_err_carry]    = (dut_carry    != w_gold_carry);
        w_flags[c_err_zero]     = (dut_zero     != w_gold_zero);
        w_flags[c_err_overflow] = (dut_overflow != w_gold_overflow);
    end

    logic w_mismatch;   // comparison this cycle failed
    logic w_count_chk;  // comparison is counted (clear has priority)
    logic w_count_mis;  // mismatch is counted / captured

    assign w_mismatch  = w_tail_valid && (|w_flags);
    assign w_count_chk = w_tail_valid && !clear;
    assign w_count_mis = w_mismatch && !clear;

    // ------------------------------------------------------------------
    // Saturating counters (next values shared with the alarm FSM so the
    // alarm rises together with the err_valid that crosses the threshold)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_mismatch_count;
    logic [CNT_W-1:0] r_check_count;
    logic [CNT_W-1:0] w_mismatch_next;
    logic [CNT_W-1:0] w_check_next;

    always_comb begin
        w_mismatch_next = r_mismatch_count;
        w_check_next    = r_check_count;
        if (clear) begin
            w_mismatch_next = '0;
            w_check_next    = '0;
        end else begin
            if (w_count_mis && (r_mismatch_count != c_cnt_max)) begin
                w_mismatch_next = r_mismatch_count + c_cnt_one;
            end
            if (w_count_chk && (r_check_count != c_cnt_max)) begin
                w_check_next = r_check_count + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Alarm FSM
    // ------------------------------------------------------------------
    state_e r_state;
    state_e w_state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ARMED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ARMED: begin
                if (w_count_mis && (w_mismatch_next >= c_thresh)) begin
                    w_state_next = ST_TRIPPED;
                end
            end
            ST_TRIPPED: begin
                if (clear) begin
                    w_state_next = ST_ARMED;
                end
            end
            default: w_state_next = ST_ARMED;
        endcase
    end

    // ------------------------------------------------------------------
    // Result, counter and capture registers
    // ------------------------------------------------------------------
    logic               r_chk_valid;
    logic               r_err_valid;
    logic [c_err_w-1:0] r_err_flags;
    logic               r_cap_valid;
    logic [WIDTH-1:0]   r_cap_a;
    logic [WIDTH-1:0]   r_cap_b;
    logic [1:0]         r_cap_op;
    logic [WIDTH-1:0]   r_cap_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_valid      <= 1'b0;
            r_err_valid      <= 1'b0;
            r_err_flags      <= '0;
            r_mismatch_count <= '0;
            r_check_count    <= '0;
            r_cap_valid      <= 1'b0;
            r_cap_a          <= '0;
            r_cap_b          <= '0;
            r_cap_op         <= '0;
            r_cap_result     <= '0;
        end else begin
            // The pulses report every comparison, even one swallowed by clear.
            r_chk_valid      <= w_tail_valid;
            r_err_valid      <= w_mismatch;
            r_err_flags      <= w_tail_valid ? w_flags : '0;
            r_mismatch_count <= w_mismatch_next;
            r_check_count    <= w_check_next;
            if (clear) begin
                r_cap_valid  <= 1'b0;
                r_cap_a      <= '0;
                r_cap_b      <= '0;
                r_cap_op     <= '0;
                r_cap_result <= '0;
            end else if (w_count_mis && !r_cap_valid) begin
                r_cap_valid  <= 1'b1;
                r_cap_a      <= w_tail_a;
                r_cap_b      <= w_tail_b;
                r_cap_op     <= w_tail_op;
                r_cap_result <= dut_result;
            end
        end
    end

    assign chk_valid      = r_chk_valid;
    assign err_valid      = r_err_valid;
    assign err_flags      = r_err_flags;
    assign mismatch_count = r_mismatch_count;
    assign check_count    = r_check_count;
    assign alarm          = (r_state == ST_TRIPPED);
    assign cap_valid      = r_cap_valid;
    assign cap_A          = r_cap_a;
    assign cap_B          = r_cap_b;
    assign cap_op         = r_cap_op;
    assign cap_result     = r_cap_result;

endmodule : alu_result_checker
`default_nettype wire

// File: tb/tb_alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_checker
// Purpose  : Directed testbench for alu_result_checker. Three instances share
//            one stimulus stream:
//              ua - latency 1, 8-bit counters, alarm threshold 1
//              ub - latency 1, 4-bit counters, alarm threshold 3
//              uc - latency 2, 8-bit counters (reset mid-flight only)
//            Each step drives the operands of one transaction together with
//            the ALU outputs belonging to the previous one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_checker;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] dut_result;
    logic       dut_carry;
    logic       dut_zero;
    logic       dut_overflow;
    logic       clear;

    logic       ua_chk_valid, ua_err_valid, ua_alarm, ua_cap_valid;
    logic [3:0] ua_err_flags, ua_cap_a, ua_cap_b, ua_cap_result;
    logic [1:0] ua_cap_op;
    logic [7:0] ua_mismatch_count, ua_check_count;

    logic       ub_chk_valid, ub_err_valid, ub_alarm, ub_cap_valid;
    logic [3:0] ub_err_flags, ub_cap_a, ub_cap_b, ub_cap_result;
    logic [1:0] ub_cap_op;
    logic [3:0] ub_mismatch_count, ub_check_count;

    logic       uc_chk_valid, uc_err_valid, uc_alarm, uc_cap_valid;
    logic [3:0] uc_err_flags, uc_cap_a, uc_cap_b, uc_cap_result;
    logic [1:0] uc_cap_op;
    logic [7:0] uc_mismatch_count, uc_check_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_result_checker #(.WIDTH(4), .DUT_LATENCY(1), .CNT_W(8), .ALARM_THRESH(1)) ua (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .op(op),
        .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
        .dut_overflow(dut_overflow), .clear(clear),
        .chk_valid(ua_chk_valid), .err_valid(ua_err_valid), .err_flags(ua_err_flags),
        .mismatch_count(ua_mismatch_count), .check_count(ua_check_count),
        .alarm(ua_alarm), .cap_valid(ua_cap_valid), .cap_A(ua_cap_a), .cap_B(ua_cap_b),
        .cap_op(ua_cap_op), .cap_result(ua_cap_result)
    );

    alu_result_checker #(.WIDTH(4), .DUT_LATENCY(1), .CNT_W(4), .ALARM_THRESH(3)) ub (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .op(op),
        .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
        .dut_overflow(dut_overflow), .clear(clear),
        .chk_valid(ub_chk_valid), .err_valid(ub_err_valid), .err_flags(ub_err_flags),
        .mismatch_count(ub_mismatch_count), .check_count(ub_check_count),
        .alarm(ub_alarm), .cap_valid(ub_cap_valid), .cap_A(ub_cap_a), .cap_B(ub_cap_b),
        .cap_op(ub_cap_op), .cap_result(ub_cap_result)
    );

    alu_result_checker #(.WIDTH(4), .DUT_LATENCY(2), .CNT_W(8), .ALARM_THRESH(1)) uc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .op(op),
        .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
        .dut_overflow(dut_overflow), .clear(clear),
        .chk_valid(uc_chk_valid), .err_valid(uc_err_valid), .err_flags(uc_err_flags),
        .mismatch_count(uc_mismatch_count), .check_count(uc_check_count),
        .alarm(uc_alarm), .cap_valid(uc_cap_valid), .cap_A(uc_cap_a), .cap_B(uc_cap_b),
        .cap_op(uc_cap_op), .cap_result(uc_cap_result)
    );

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [3:0] ia, input logic [3:0] ib,
                        input logic [1:0] iop, input logic [3:0] r, input logic c,
                        input logic z, input logic o, input logic clr);
        in_valid     = v;
        a            = ia;
        b            = ib;
        op           = iop;
        dut_result   = r;
        dut_carry    = c;
        dut_zero     = z;
        dut_overflow = o;
        clear        = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        step(0, 0, 0, OP_ADD, 0, 0, 0, 0, 0);
        step(0, 0, 0, OP_ADD, 0, 0, 0, 0, 0);

        // Reset state
        check_value("rst_chk_valid", ua_chk_valid, 0);
        check_value("rst_err_flags", ua_err_flags, 0);
        check_value("rst_mis_cnt", ua_mismatch_count, 0);
        check_value("rst_chk_cnt", ua_check_count, 0);
        check_value("rst_alarm", ua_alarm, 0);
        check_value("rst_cap_valid", ua_cap_valid, 0);
        check_value("rst_ub_alarm", ub_alarm, 0);
        rst = 1'b0;

        // Clean ADD 7+1 -> 8, c0 z0 v1
        step(1, 4'h7, 4'h1, OP_ADD, 0, 0, 0, 0, 0);
        check_value("add_no_tail", ua_chk_valid, 0);
        // SUB 0-1 launched; ADD result returned
        step(1, 4'h0, 4'h1, OP_SUB, 4'h8, 0, 0, 1, 0);
        check_value("add_chk_valid", ua_chk_valid, 1);
        check_value("add_err_valid", ua_err_valid, 0);
        check_value("add_chk_cnt", ua_check_count, 1);
        // SUB 8-1 launched; 0-1 returns F, c0 z0 v0 (correct)
        step(1, 4'h8, 4'h1, OP_SUB, 4'hF, 0, 0, 0, 0);
        check_value("sub0_err_valid", ua_err_valid, 0);
        check_value("sub0_chk_cnt", ua_check_count, 2);
        // 8-1 should be 7, c1 z0 v1; carry corrupted to 0
        step(0, 0, 0, OP_ADD, 4'h7, 0, 0, 1, 0);
        check_value("sub8_err_valid", ua_err_valid, 1);
        check_value("sub8_err_flags", ua_err_flags, 4'b0100);
        check_value("sub8_mis_cnt", ua_mismatch_count, 1);
        check_value("sub8_alarm", ua_alarm, 1);
        check_value("sub8_cap_valid", ua_cap_valid, 1);
        check_value("sub8_cap", {ua_cap_a, ua_cap_b, ua_cap_op, ua_cap_result},
                    {4'h8, 4'h1, 2'b01, 4'h7});
        check_value("ub_th1_alarm", ub_alarm, 0);
        check_value("ub_th1_mis", ub_mismatch_count, 1);

        // Two AND F&0 with zero flag corrupted (expect z=1, DUT says 0)
        step(1, 4'hF, 4'h0, OP_AND, 0, 0, 0, 0, 0);
        check_value("idle_chk_valid", ua_chk_valid, 0);
        step(1, 4'hF, 4'h0, OP_AND, 4'h0, 0, 0, 0, 0);
        check_value("ub_th2_flags", ub_err_flags, 4'b0010);
        check_value("ub_th2_alarm", ub_alarm, 0);
        step(0, 0, 0, OP_ADD, 4'h0, 0, 0, 0, 0);
        check_value("ub_th3_err_valid", ub_err_valid, 1);
        check_value("ub_th3_alarm", ub_alarm, 1);
        check_value("ub_th3_mis", ub_mismatch_count, 3);

        // Ten clean OR ops (A | 0 = A)
        for (int k = 0; k <= 10; k++) begin
            step(k < 10, 4'(k + 1), 4'h0, OP_OR, 4'(k), 0, 0, 0, 0);
            if (k > 0) check_value("clean_err_valid", ub_err_valid, 0);
        end
        check_value("sticky_alarm", ub_alarm, 1);
        check_value("sticky_cap",
                    {ub_cap_valid, ub_cap_a, ub_cap_b, ub_cap_op, ub_cap_result},
                    {1'b1, 4'h8, 4'h1, 2'b01, 4'h7});
        check_value("sticky_mis", ub_mismatch_count, 3);
        check_value("ua_chk_cnt15", ua_check_count, 15);

        // Twenty ADD 0+0 mismatches (zero flag reported as 0)
        for (int j = 0; j <= 20; j++) begin
            step(j < 20, 4'h0, 4'h0, OP_ADD, 4'h0, 0, 0, 0, 0);
        end
        check_value("sat_flags", ua_err_flags, 4'b0010);
        check_value("sat_ub_mis", ub_mismatch_count, 15);
        check_value("sat_ub_chk", ub_check_count, 15);
        check_value("sat_ua_mis", ua_mismatch_count, 23);
        check_value("sat_ua_chk", ua_check_count, 35);

        // clear coincident with a mismatch
        step(1, 4'h0, 4'h0, OP_ADD, 0, 0, 0, 0, 0);
        step(0, 0, 0, OP_ADD, 4'h0, 0, 0, 0, 1);
        check_value("clr_err_valid", ua_err_valid, 1);
        check_value("clr_mis_cnt", ua_mismatch_count, 0);
        check_value("clr_chk_cnt", ua_check_count, 0);
        check_value("clr_alarm", ua_alarm, 0);
        check_value("clr_cap_valid", ua_cap_valid, 0);
        check_value("clr_cap_a", ua_cap_a, 0);
        check_value("clr_ub_alarm", ub_alarm, 0);
        step(0, 0, 0, OP_ADD, 0, 0, 0, 0, 0);
        check_value("post_clr_chk", ua_chk_valid, 0);
        check_value("post_clr_mis", ua_mismatch_count, 0);

        // Reset with two transactions in flight in the latency-2 checker
        step(1, 4'h3, 4'h4, OP_ADD, 0, 0, 0, 0, 0);
        step(1, 4'h5, 4'h6, OP_SUB, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step(0, 0, 0, OP_ADD, 0, 0, 0, 0, 0);
        check_value("rstf_chk_valid", uc_chk_valid, 0);
        check_value("rstf_outputs",
                    {uc_err_valid, uc_err_flags, uc_mismatch_count, uc_check_count,
                     uc_alarm, uc_cap_valid},
                    0);
        rst = 1'b0;
        step(0, 0, 0, OP_ADD, 0, 0, 0, 0, 0);
        check_value("rstf_chk1", uc_chk_valid, 0);
        step(0, 0, 0, OP_ADD, 0, 0, 0, 0, 0);
        check_value("rstf_chk2", uc_chk_valid, 0);
        check_value("rstf_cnt", uc_check_count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_result_checker
`default_nettype wire
